// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth checker.
// Holds state encoding and reference truth tables of basic gates.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  localparam logic [3:0] EXP_OR   = 4'b1110;
  localparam logic [3:0] EXP_AND  = 4'b1000;
  localparam logic [3:0] EXP_NAND = 4'b0111;
  localparam logic [3:0] EXP_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Bundle between the checker, its requester and the gate under test.
// master = requester/GUT side, slave = checker side.
interface gate_truth_checker_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic [N_IN-1:0] vec_out;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;

  modport master (
    output start, dut_out,
    input  vec_out, busy, done, pass,
    input  err_count, first_fail_vec
  );

  modport slave (
    input  start, dut_out,
    output vec_out, busy, done, pass,
    output err_count, first_fail_vec
  );

endinterface

// File: rtl/gate_settle_counter.sv
// Loadable 8-bit down-counter with a zero flag.
// Paces the idle cycles between applying and sampling a vector.
module gate_settle_counter
  import gate_check_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // load has priority over decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table sweep of a gate under test, scored per vector.
// Define GATE_CHECK_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                  N_IN     = 2,
  parameter int                  SETTLE   = 1,
  parameter logic [2**N_IN-1:0]  EXPECTED = EXP_OR
) (
  input logic            clk,
  input logic            reset,
  gate_truth_checker_if.slave io
);

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [N_IN-1:0]  LAST     = '1;
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

  state_t state, state_n;

  logic [N_IN-1:0]  vec_q, vec_n;
  logic [N_IN:0]    err_q, err_n;
  logic [N_IN-1:0]  ffv_q, ffv_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             pass_q, pass_n;
  logic             cnt_load, cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             mismatch;

  gate_settle_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (SETTLE_V),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign mismatch = (io.dut_out != EXPECTED[vec_q]);

  // state and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      vec_q  <= '0;
      err_q  <= '0;
      ffv_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_n;
      vec_q  <= vec_n;
      err_q  <= err_n;
      ffv_q  <= ffv_n;
      busy_q <= busy_n;
      done_q <= done_n;
      pass_q <= pass_n;
    end
  end

  // sweep sequencing and scoring
  always_comb begin
    state_n  = state;
    vec_n    = vec_q;
    err_n    = err_q;
    ffv_n    = ffv_q;
    busy_n   = busy_q;
    done_n   = done_q;
    pass_n   = pass_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (io.start) begin
          state_n  = WAIT;
          vec_n    = '0;
          err_n    = '0;
          ffv_n    = '0;
          busy_n   = 1'b1;
          done_n   = 1'b0;
          pass_n   = 1'b0;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          if (mismatch) begin
            err_n = err_q + 1'b1;
            if (err_q == '0)
              ffv_n = vec_q;
          end
          if (vec_q == LAST ||
              (STOP_ON_FAIL && mismatch)) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end else begin
            vec_n    = vec_q + 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign io.vec_out        = vec_q;
  assign io.err_count      = err_q;
  assign io.first_fail_vec = ffv_q;
  assign io.busy           = busy_q;
  assign io.done           = done_q;
  assign io.pass           = pass_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: OR/AND/stuck GUTs,
// reset abort, busy start, and a 3-input SETTLE=0 instance.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mode = 2'd0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gate_truth_checker_if #(.N_IN(2)) a_if ();
  gate_truth_checker_if #(.N_IN(3)) b_if ();

  gate_truth_checker #(
    .N_IN(2), .SETTLE(1), .EXPECTED(4'b1110)
  ) dut_a (
    .clk(clk), .reset(reset), .io(a_if.slave)
  );

  gate_truth_checker #(
    .N_IN(3), .SETTLE(0), .EXPECTED(8'b1111_1110)
  ) dut_b (
    .clk(clk), .reset(reset), .io(b_if.slave)
  );

  // GUT models: 0 = OR, 1 = AND, else stuck-at-1
  always_comb begin
    case (mode)
      2'd0:    a_if.dut_out = |a_if.vec_out;
      2'd1:    a_if.dut_out = &a_if.vec_out;
      default: a_if.dut_out = 1'b1;
    endcase
  end

  assign b_if.dut_out = |b_if.vec_out;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // pulse start, count edges after the start edge until done
  task automatic run_a(input bit pulse2,
                       output int n,
                       output logic [15:0] seq);
    n = 0;
    seq = '0;
    @(negedge clk);
    a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    seq[1:0] = a_if.vec_out;
    while (!a_if.done && n < 100) begin
      if (pulse2 && n == 1) begin
        @(negedge clk);
        a_if.start = 1'b1;
      end
      @(posedge clk);
      n++;
      #1;
      a_if.start = 1'b0;
      if (n < 8) seq[2*n +: 2] = a_if.vec_out;
    end
  endtask

  int n;
  logic [15:0] seq;

  initial begin
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vec", a_if.vec_out, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_pass", a_if.pass, 0);
    chk("rst_err", a_if.err_count, 0);
    chk("rst_ffv", a_if.first_fail_vec, 0);
    reset = 1'b0;

    // correct OR
    mode = 2'd0;
    run_a(1'b0, n, seq);
    chk("or_lat", n, 8);
    chk("or_seq", seq, 16'hFA50);
    chk("or_done", a_if.done, 1);
    chk("or_pass", a_if.pass, 1);
    chk("or_err", a_if.err_count, 0);
    chk("or_busy", a_if.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("or_hold_done", a_if.done, 1);
    chk("or_hold_vec", a_if.vec_out, 3);

    // AND in place of OR
    mode = 2'd1;
    run_a(1'b0, n, seq);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    chk("and_lat", n, 4);
    chk("and_err", a_if.err_count, 1);
    chk("and_vec", a_if.vec_out, 1);
`else
    chk("and_lat", n, 8);
    chk("and_err", a_if.err_count, 2);
`endif
    chk("and_ffv", a_if.first_fail_vec, 1);
    chk("and_pass", a_if.pass, 0);
    chk("and_done", a_if.done, 1);

    // stuck-at-1
    mode = 2'd2;
    run_a(1'b0, n, seq);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    chk("s1_lat", n, 2);
`else
    chk("s1_lat", n, 8);
`endif
    chk("s1_err", a_if.err_count, 1);
    chk("s1_ffv", a_if.first_fail_vec, 0);
    chk("s1_pass", a_if.pass, 0);

    // restart from DONE with correct OR
    mode = 2'd0;
    run_a(1'b0, n, seq);
    chk("re_lat", n, 8);
    chk("re_err", a_if.err_count, 0);
    chk("re_ffv", a_if.first_fail_vec, 0);
    chk("re_pass", a_if.pass, 1);

    // reset 3 edges into a sweep
    mode = 2'd2;
    @(negedge clk);
    a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ab_busy_pre", a_if.busy, 1);
    reset = 1'b1;
    #1;
    chk("ab_vec", a_if.vec_out, 0);
    chk("ab_busy", a_if.busy, 0);
    chk("ab_done", a_if.done, 0);
    chk("ab_pass", a_if.pass, 0);
    chk("ab_err", a_if.err_count, 0);
    chk("ab_ffv", a_if.first_fail_vec, 0);
    @(negedge clk);
    reset = 1'b0;
    mode = 2'd0;

    // full run with a start pulse at edge 2
    run_a(1'b1, n, seq);
    chk("bs_lat", n, 8);
    chk("bs_seq", seq, 16'hFA50);
    chk("bs_pass", a_if.pass, 1);

    // 3-input OR, SETTLE=0
    @(negedge clk);
    b_if.start = 1'b1;
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
    n = 0;
    while (!b_if.done && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("b_lat", n, 8);
    chk("b_pass", b_if.pass, 1);
    chk("b_err", b_if.err_count, 0);
    chk("b_vec", b_if.vec_out, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Synthesizable, clocked counterpart of the combinational gate benches: drives every input combination into a gate under test (GUT), samples its output, and scores it against a parameterised truth table.
- Sits beside any project-1 style gate (student_or etc.) on the FPGA/BIST path.
- Reports pass/fail, the mismatch count and the first failing vector.

Parameters:
- N_IN, 2, number of GUT inputs; exhaustive sweep of 2^N_IN vectors.
- SETTLE, 1, idle cycles after applying a vector before sampling (0..255).
- EXPECTED, 4'b1110, width 2^N_IN; bit i = required GUT output for input vector i (default = OR).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle request to run a sweep.
- vec_out  output  N_IN  vector driven to GUT inputs (bit0 = LSB input, e.g. b; bit1 = a).
- dut_out  input  1  GUT output.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors (max 2^N_IN).
- first_fail_vec  output  N_IN  first mismatching vector; meaningful only when err_count!=0.

Behaviour:
- Reset (async, any state): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, settle counter=0.
- States: IDLE, WAIT, DONE. All outputs registered.
- IDLE: start=1 at edge E0 -> WAIT; vec_out=0, cnt=SETTLE, busy=1, err_count=0, done=0.
- WAIT, cnt!=0: cnt decrements; vec_out held.
- WAIT, cnt==0 (sample edge): compare dut_out to EXPECTED[vec_out]. On mismatch, err_count+1; if err_count was 0, first_fail_vec=vec_out.
  - If vec_out==2^N_IN-1 -> DONE on the same edge (busy=0, done=1, pass from final count including this sample).
  - Otherwise vec_out+1 and cnt=SETTLE.
- Latency: each vector occupies SETTLE+1 edges; done is high after E0+2^N_IN*(SETTLE+1) edges (default: 8).
- vec_out never wraps during a sweep; the sweep ends at the all-ones vector.
- start while busy: ignored, no restart.
- DONE: outputs frozen. start=1 -> WAIT exactly as from IDLE (clears err_count, first_fail_vec, done, pass).
- dut_out is treated as synchronous to clk; no internal synchroniser.
- err_count saturation is impossible by width choice.
- reset during WAIT aborts immediately to reset values; no partial result is kept.

Optional Feature:
- Macro GATE_CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatching sample ends the sweep (-> DONE on that edge, err_count=1, first_fail_vec=failing vector, vec_out held at that vector).
- Undefined: the sweep always covers all 2^N_IN vectors and counts every mismatch.

Decomposition:
- Shared package gate_check_pkg: state encoding constants (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), default EXPECTED constants for project-1 gates (OR 4'b1110, AND 4'b1000, NAND 4'b0111, XOR 4'b0110).
- One natural sub-module: gate_settle_counter (loadable down-counter with zero flag, width 8).

Test Plan:
- Defaults, GUT = correct OR, pulse start -> done=1 and pass=1 exactly 8 edges after start edge; err_count=0; vec_out sequence 0,0,1,1,2,2,3,3.
- Defaults, GUT = AND -> mismatches at vectors 1 and 2; done after 8 edges; err_count=2, first_fail_vec=1, pass=0.
- Defaults, GUT stuck-at-1 -> err_count=1, first_fail_vec=0, pass=0; second start from DONE with a correct OR -> err_count cleared, pass=1 after 8 edges.
- Assert reset 3 edges into a sweep -> all outputs 0 immediately (no clock edge needed); start after release gives a full, correct 8-edge run. Also pulse start at edge 2 while busy -> no effect on sequence or latency.
- SETTLE=0, N_IN=3, EXPECTED=8'b1111_1110 (3-input OR), correct GUT -> done after 8 edges, pass=1.
- GATE_CHECK_STOP_ON_FAIL_EN defined, defaults, GUT = AND -> done after 4 edges, err_count=1, first_fail_vec=1, vec_out stays 1, pass=0.
